// File: rtl/ddcq_pkg.sv
// Shared defaults, octant encoding and fixed-point helpers for the DDC NCO mixer.
package ddcq_pkg;

  localparam int unsigned DATA_W_DEF  = 12;
  localparam int unsigned PHASE_W_DEF = 24;
  localparam int unsigned LUT_AW_DEF  = 9;
  localparam int unsigned LUT_DW_DEF  = 8;

  typedef enum logic [2:0] {
    OCT0, OCT1, OCT2, OCT3, OCT4, OCT5, OCT6, OCT7
  } oct_e;

  // floor(x / 2^sh + 1/2) on a sign-extended value
  function automatic logic signed [31:0] round_half_up(input logic signed [31:0] x,
                                                       input int unsigned     sh);
    return (x + (32'sd1 <<< (sh - 32'd1))) >>> sh;
  endfunction

  function automatic logic clips(input logic signed [31:0] x, input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 32'd1));
    return (x > hi) || (x < lo);
  endfunction

  function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                  input int unsigned     w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 32'd1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/ddcq_sincos_lut.sv
// Eighth-wave cos/sin ROM over [0, pi/4), sampled at bin centres, scaled so 2^LUT_DW-1 ~ 1.0.
module ddcq_sincos_lut
  import ddcq_pkg::*;
#(
  parameter int unsigned LUT_AW = LUT_AW_DEF,
  parameter int unsigned LUT_DW = LUT_DW_DEF
) (
  input  logic [LUT_AW-1:0] addr_i,
  output logic [LUT_DW-1:0] cos_o,
  output logic [LUT_DW-1:0] sin_o
);

  localparam int unsigned DEPTH   = 1 << LUT_AW;
  localparam longint      ONE_Q30 = 64'sd1073741824;
  localparam longint      PI_Q30  = 64'sd3373259426;
  localparam longint      SCALE   = longint'((1 << LUT_DW) - 1);

  // Elaboration-time Taylor series in Q30; angle = (idx + 0.5) * (pi/4) / DEPTH
  function automatic logic [LUT_DW-1:0] tab_val(input longint idx, input logic want_sin);
    longint x;
    longint t;
    longint s;
    x = ((2 * idx + 1) * PI_Q30) >>> (LUT_AW + 3);
    if (want_sin) begin
      t = x;
      s = x;
    end else begin
      t = ONE_Q30;
      s = ONE_Q30;
    end
    for (int unsigned n = 1; n <= 8; n++) begin
      t = (t * x) / ONE_Q30;
      t = (t * x) / ONE_Q30;
      t = -t / (want_sin ? longint'(2 * n * (2 * n + 1)) : longint'((2 * n - 1) * 2 * n));
      s = s + t;
    end
    return LUT_DW'((s * SCALE + ONE_Q30 / 2) / ONE_Q30);
  endfunction

  logic [LUT_DW-1:0] cos_tab [DEPTH];
  logic [LUT_DW-1:0] sin_tab [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    localparam logic [LUT_DW-1:0] CV = tab_val(longint'(g), 1'b0);
    localparam logic [LUT_DW-1:0] SV = tab_val(longint'(g), 1'b1);
    assign cos_tab[g] = CV;
    assign sin_tab[g] = SV;
  end

  always_comb begin
    cos_o = cos_tab[addr_i];
    sin_o = sin_tab[addr_i];
  end

endmodule

// File: rtl/ddcq_nco_mixer.sv
// RX quadrature mixer: x * e^(-j*theta) from a folded eighth-wave NCO, 3-cycle latency.
// Optional phase dither via `define DDCQ_PHASE_DITHER_EN.
module ddcq_nco_mixer
  import ddcq_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned LUT_AW  = LUT_AW_DEF,
  parameter int unsigned LUT_DW  = LUT_DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PHASE_W-1:0]       phase_inc,
  input  logic [PHASE_W-1:0]       phase_ofs,
  input  logic                     sync_clr,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_i,
  output logic signed [DATA_W-1:0] out_q,
  output logic                     sat
);

  localparam int unsigned TW = 3 + LUT_AW;
  localparam int unsigned CW = LUT_DW + 1;
  localparam int unsigned PW = DATA_W + LUT_DW + 1;
  localparam int unsigned SW = PW + 1;

  logic [PHASE_W-1:0]       acc_q, acc_d;
  logic [TW-1:0]            theta_top;
  oct_e                     oct;
  logic [LUT_AW-1:0]        lut_addr;
  logic [LUT_DW-1:0]        lut_c, lut_s;
  logic signed [CW-1:0]     cmag, smag;
  logic signed [CW-1:0]     cos_d, sin_d, cos_q, sin_q;
  logic signed [DATA_W-1:0] i0_q, q0_q;
  logic                     v0_q, v1_q;
  logic signed [PW-1:0]     pic_d, pqs_d, pqc_d, pis_d;
  logic signed [PW-1:0]     pic_q, pqs_q, pqc_q, pis_q;
  logic signed [SW-1:0]     ii, qi;
  logic signed [31:0]       ri, rq;
  logic signed [DATA_W-1:0] out_i_d, out_q_d, out_i_q, out_q_q;
  logic                     sat_d, sat_q, out_valid_q;

  always_comb begin
    acc_d = acc_q;
    if (sync_clr)      acc_d = in_valid ? phase_ofs + phase_inc : phase_ofs;
    else if (in_valid) acc_d = acc_q + phase_inc;
  end

`ifdef DDCQ_PHASE_DITHER_EN
  localparam int unsigned DITH_W = PHASE_W - TW;
  logic [14:0]        lfsr_q, lfsr_d;
  logic [PHASE_W-1:0] theta_dith;

  always_comb begin
    lfsr_d = lfsr_q;
    if (in_valid) lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    theta_dith = (sync_clr ? phase_ofs : acc_q) + PHASE_W'(lfsr_q[DITH_W-1:0]);
    theta_top  = theta_dith[PHASE_W-1 -: TW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 15'h0001;
    else        lfsr_q <= lfsr_d;
  end
`else
  always_comb begin
    theta_top = sync_clr ? phase_ofs[PHASE_W-1 -: TW] : acc_q[PHASE_W-1 -: TW];
  end
`endif

  // Lookup and fold run off the pre-update phase ahead of the first register,
  // so capture/lookup share one stage and multiply/combine keep the other two.
  ddcq_sincos_lut #(
    .LUT_AW (LUT_AW),
    .LUT_DW (LUT_DW)
  ) u_lut (
    .addr_i (lut_addr),
    .cos_o  (lut_c),
    .sin_o  (lut_s)
  );

  always_comb begin
    lut_addr = theta_top[LUT_AW-1:0] ^ {LUT_AW{theta_top[LUT_AW]}};
    oct      = oct_e'(theta_top[TW-1 -: 3]);
    cmag     = $signed({1'b0, lut_c});
    smag     = $signed({1'b0, lut_s});
    cos_d    = cmag;
    sin_d    = smag;
    case (oct)
      OCT0:    begin cos_d =  cmag; sin_d =  smag; end
      OCT1:    begin cos_d =  smag; sin_d =  cmag; end
      OCT2:    begin cos_d = -smag; sin_d =  cmag; end
      OCT3:    begin cos_d = -cmag; sin_d =  smag; end
      OCT4:    begin cos_d = -cmag; sin_d = -smag; end
      OCT5:    begin cos_d = -smag; sin_d = -cmag; end
      OCT6:    begin cos_d =  smag; sin_d = -cmag; end
      OCT7:    begin cos_d =  cmag; sin_d = -smag; end
      default: begin cos_d =  cmag; sin_d =  smag; end
    endcase
  end

  always_comb begin
    pic_d = PW'(i0_q) * PW'(cos_q);
    pqs_d = PW'(q0_q) * PW'(sin_q);
    pqc_d = PW'(q0_q) * PW'(cos_q);
    pis_d = PW'(i0_q) * PW'(sin_q);
  end

  always_comb begin
    ii      = SW'(pic_q) + SW'(pqs_q);
    qi      = SW'(pqc_q) - SW'(pis_q);
    ri      = round_half_up(32'(ii), LUT_DW);
    rq      = round_half_up(32'(qi), LUT_DW);
    out_i_d = DATA_W'(saturate(ri, DATA_W));
    out_q_d = DATA_W'(saturate(rq, DATA_W));
    sat_d   = v1_q && (clips(ri, DATA_W) || clips(rq, DATA_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      i0_q        <= '0;
      q0_q        <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      pic_q       <= '0;
      pqs_q       <= '0;
      pqc_q       <= '0;
      pis_q       <= '0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      v0_q        <= in_valid;
      v1_q        <= v0_q;
      out_valid_q <= v1_q;
      sat_q       <= sat_d;
      if (in_valid) begin
        i0_q  <= in_i;
        q0_q  <= in_q;
        cos_q <= cos_d;
        sin_q <= sin_d;
      end
      if (v0_q) begin
        pic_q <= pic_d;
        pqs_q <= pqs_d;
        pqc_q <= pqc_d;
        pis_q <= pis_d;
      end
      if (v1_q) begin
        out_i_q <= out_i_d;
        out_q_q <= out_q_d;
      end
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    out_i     = out_i_q;
    out_q     = out_q_q;
    sat       = sat_q;
  end

endmodule

// File: tb/tb_ddcq_nco_mixer.sv
// Scoreboard bench for ddcq_nco_mixer: real-valued NCO/mixer reference, directed and random stimulus.
module tb_ddcq_nco_mixer;

  logic               clk;
  logic               rst_n;
  logic [23:0]        phase_inc;
  logic [23:0]        phase_ofs;
  logic               sync_clr;
  logic               in_valid;
  logic signed [11:0] in_i;
  logic signed [11:0] in_q;
  logic               out_valid;
  logic signed [11:0] out_i;
  logic signed [11:0] out_q;
  logic               sat;

  ddcq_nco_mixer #(
    .DATA_W  (12),
    .PHASE_W (24),
    .LUT_AW  (9),
    .LUT_DW  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase_inc (phase_inc),
    .phase_ofs (phase_ofs),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .in_i      (in_i),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_i     (out_i),
    .out_q     (out_q),
    .sat       (sat)
  );

  typedef struct {
    int     i;
    int     q;
    bit     s;
    longint cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  longint      cyc      = 0;
  int          last_i   = 0;
  int          last_q   = 0;
  logic [23:0] acc_m    = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int quant(input real x);
    if (x < 0.0) return -int'($floor(-255.0 * x + 0.5));
    else         return int'($floor(255.0 * x + 0.5));
  endfunction

  // Mix at the centre of the table bin containing theta, with magnitudes rounded to 8 bits.
  task automatic model(input logic [23:0] theta, input int i, input int q,
                       output int ei, output int eq, output bit es);
    real phi;
    int  qc, qs, xi, xq, ri, rq;
    phi = 2.0 * 3.14159265358979323846 *
          (real'(theta >> 12) * 4096.0 + 2048.0) / 16777216.0;
    qc  = quant($cos(phi));
    qs  = quant($sin(phi));
    xi  = i * qc + q * qs;
    xq  = q * qc - i * qs;
    ri  = (xi + 128) >>> 8;
    rq  = (xq + 128) >>> 8;
    es  = (ri > 2047) || (ri < -2048) || (rq > 2047) || (rq < -2048);
    ei  = (ri > 2047) ? 2047 : (ri < -2048) ? -2048 : ri;
    eq  = (rq > 2047) ? 2047 : (rq < -2048) ? -2048 : rq;
  endtask

  task automatic drive(input bit v, input bit clr, input logic [23:0] inc,
                       input logic [23:0] ofs, input int i, input int q,
                       input bit use_exp, input int xi, input int xq, input bit xs);
    exp_t        e;
    logic [23:0] theta;
    @(posedge clk);
    #1;
    in_valid  = v;
    sync_clr  = clr;
    phase_inc = inc;
    phase_ofs = ofs;
    in_i      = 12'(i);
    in_q      = 12'(q);
    if (v) begin
      theta = clr ? ofs : acc_m;
      if (use_exp) begin
        e.i = xi;
        e.q = xq;
        e.s = xs;
      end else begin
        model(theta, i, q, e.i, e.q, e.s);
      end
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
    if (clr)    acc_m = v ? ofs + inc : ofs;
    else if (v) acc_m = acc_m + inc;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 24'h0, 24'h0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_i", out_i, e.i);
        chk("out_q", out_q, e.q);
        chk("sat", sat, e.s);
        chk("latency_cycle", cyc, e.cyc);
        last_i = e.i;
        last_q = e.q;
      end
    end else begin
      chk("sat_idle", sat, 0);
      chk("hold_i", out_i, last_i);
      chk("hold_q", out_q, last_q);
    end
  end

  initial begin
    int seq_i[4];
    int seq_q[4];
    seq_i = '{996, 0, -996, 0};
    seq_q = '{0, -996, 0, 996};

    rst_n = 1'b1; in_valid = 1'b0; sync_clr = 1'b0;
    phase_inc = '0; phase_ofs = '0; in_i = '0; in_q = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_i", out_i, 0);
    chk("reset_out_q", out_q, 0);
    chk("reset_sat", sat, 0);
    #2 rst_n = 1'b1;

    // DC at zero frequency
    for (int k = 0; k < 4; k++)
      drive(1'b1, k == 0, 24'h0, 24'h0, 1000, 0, 1'b1, 996, 0, 1'b0);
    // fs/4 rotation
    for (int k = 0; k < 8; k++)
      drive(1'b1, k == 0, 24'h400000, 24'h0, 1000, 0, 1'b1, seq_i[k % 4], seq_q[k % 4], 1'b0);
    // pi/4 with full-scale input saturates I
    for (int k = 0; k < 3; k++)
      drive(1'b1, k == 0, 24'h0, 24'h200000, 2047, 2047, 1'b1, 2047, 0, 1'b1);
    idle(2);
    // gapped input: accumulator advances only on accepted samples
    drive(1'b0, 1'b1, 24'h400000, 24'h0, 0, 0, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 24'h400000, 24'h0, 1000, 0, 1'b1, 996, 0, 1'b0);
    drive(1'b0, 1'b0, 24'h400000, 24'h0, 1000, 0, 1'b0, 0, 0, 1'b0);
    drive(1'b0, 1'b0, 24'h400000, 24'h0, 1000, 0, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 24'h400000, 24'h0, 1000, 0, 1'b1, 0, -996, 1'b0);
    drive(1'b1, 1'b0, 24'h400000, 24'h0, 1000, 0, 1'b1, -996, 0, 1'b0);
    // reload and accept in the same cycle
    drive(1'b1, 1'b1, 24'h123456, 24'hC00000, 1000, 0, 1'b1, 0, 996, 1'b0);
    idle(4);

    // reset with two samples in flight
    drive(1'b1, 1'b0, 24'h031000, 24'h0, 700, -300, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 24'h031000, 24'h0, -500, 900, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0; in_valid = 1'b0; sync_clr = 1'b0;
    sb.delete();
    last_i = 0; last_q = 0; acc_m = '0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_i", out_i, 0);
    chk("midrst_out_q", out_q, 0);
    chk("midrst_sat", sat, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle(6);

    // random traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      int  ri, rq;
      bit  v, c;
      ri = int'($urandom_range(0, 4095)) - 2048;
      rq = int'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 9) == 0) begin
        ri = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
        rq = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
      end
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 19) == 0);
      drive(v, c, 24'($urandom()), 24'($urandom()), ri, rq, 1'b0, 0, 0, 1'b0);
    end
    drive(1'b0, 1'b0, 24'h0, 24'h0, 0, 0, 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_pending", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
